// File: rtl/bip_uart_defs.sv
// Shared ASCII constants and FSM state encoding for the BIP/UART print stages.
package bip_uart_defs;
  localparam logic [7:0] ASCII_0     = 8'd48;
  localparam logic [7:0] ASCII_A_OFS = 8'd55;
  localparam logic [7:0] ASCII_CR    = 8'd13;
  localparam logic [7:0] ASCII_LF    = 8'd10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SEND_DIG = 3'd1;
  localparam logic [2:0] ST_SEND_CR  = 3'd2;
  localparam logic [2:0] ST_SEND_LF  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    SEND_DIG = ST_SEND_DIG,
    SEND_CR  = ST_SEND_CR,
    SEND_LF  = ST_SEND_LF,
    DONE     = ST_DONE
  } state_t;
endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit nibble to uppercase ASCII hex character, zero-extended to N bits.
module nibble_to_ascii
  import bip_uart_defs::*;
#(
  parameter int N = 8
) (
  input  logic [3:0]   nib,
  output logic [N-1:0] ch
);
  logic [7:0] c;

  always_comb begin
    c  = (nib < 4'd10) ? (ASCII_0 + {4'd0, nib}) : (ASCII_A_OFS + {4'd0, nib});
    ch = N'(c);
  end
endmodule

// File: rtl/bip_acc_tx_formatter.sv
// Latches the BIP accumulator on start and streams it as ASCII hex (MSB nibble first)
// into the UART TX FIFO. Optional CR/LF terminator is enabled with BIP_TX_CRLF_EN.
module bip_acc_tx_formatter
  import bip_uart_defs::*;
#(
  parameter int N      = 8,
  parameter int W      = 16,
  parameter int DIGITS = W / 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] acc_in,
  input  logic         tx_full,
  output logic [N-1:0] uart_out,
  output logic         wr_uart,
  output logic         busy,
  output logic         done_tick
);
  localparam int           CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t        state;
  logic [W-1:0]  acc_reg;
  logic [CW-1:0] dig_cnt;
  logic [3:0]    nib;
  logic [N-1:0]  dig_ch;

  assign nib = 4'(acc_reg >> {dig_cnt, 2'b00});

  nibble_to_ascii #(.N(N)) u_n2a (
    .nib (nib),
    .ch  (dig_ch)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      acc_reg <= '0;
      dig_cnt <= LAST;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_reg <= acc_in;
            dig_cnt <= LAST;
            state   <= SEND_DIG;
          end
        end
        SEND_DIG: begin
          // Advance only on a cycle where the FIFO actually took the character.
          if (!tx_full) begin
            if (dig_cnt == '0) begin
`ifdef BIP_TX_CRLF_EN
              state <= SEND_CR;
`else
              state <= DONE;
`endif
            end else begin
              dig_cnt <= dig_cnt - 1'b1;
            end
          end
        end
`ifdef BIP_TX_CRLF_EN
        SEND_CR: if (!tx_full) state <= SEND_LF;
        SEND_LF: if (!tx_full) state <= DONE;
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    uart_out = '0;
    wr_uart  = 1'b0;
    case (state)
      SEND_DIG: begin
        uart_out = dig_ch;
        wr_uart  = ~tx_full;
      end
`ifdef BIP_TX_CRLF_EN
      SEND_CR: begin
        uart_out = N'(ASCII_CR);
        wr_uart  = ~tx_full;
      end
      SEND_LF: begin
        uart_out = N'(ASCII_LF);
        wr_uart  = ~tx_full;
      end
`endif
      default: ;
    endcase
  end

  assign busy      = (state != IDLE) && (state != DONE);
  assign done_tick = (state == DONE);
endmodule

// File: tb/tb_bip_acc_tx_formatter.sv
// Directed self-checking bench for bip_acc_tx_formatter; follows BIP_TX_CRLF_EN if defined.
module tb_bip_acc_tx_formatter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] acc_in = '0;
  logic        tx_full = 1'b0;
  logic [7:0]  uart_out;
  logic        wr_uart, busy, done_tick;

  int checks = 0;
  int failures = 0;

`ifdef BIP_TX_CRLF_EN
  localparam int TAIL = 2;
`else
  localparam int TAIL = 0;
`endif

  logic [7:0] seq [6];

  always #5 clk = ~clk;

  bip_acc_tx_formatter #(.N(8), .W(16), .DIGITS(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .acc_in    (acc_in),
    .tx_full   (tx_full),
    .uart_out  (uart_out),
    .wr_uart   (wr_uart),
    .busy      (busy),
    .done_tick (done_tick)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_seq(input logic [7:0] a, b, c, d);
    seq[0] = a; seq[1] = b; seq[2] = c; seq[3] = d;
    seq[4] = 8'h0D; seq[5] = 8'h0A;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (uart_out !== 8'h00 || wr_uart !== 1'b0 || busy !== 1'b0 || done_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset: ch=%h wr=%b busy=%b done=%b, want 00 0 0 0", uart_out, wr_uart, busy, done_tick);
    end
    tick();
    reset_n = 1'b1;
    tick();
    #1;
    checks++;
    if (wr_uart !== 1'b0 || busy !== 1'b0 || done_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: wr=%b busy=%b done=%b, want 0 0 0", wr_uart, busy, done_tick);
    end
  endtask

  // Digits on k+1..k+4 (+tail), done_tick right after; a start in DONE is ignored.
  task automatic test_basic();
    set_seq(8'h31, 8'h41, 8'h32, 8'h46);
    tick();
    acc_in = 16'h1A2F; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4 + TAIL; i++) begin
      #1;
      checks++;
      if (wr_uart !== 1'b1 || uart_out !== seq[i] || busy !== 1'b1 || done_tick !== 1'b0) begin
        failures++;
        $display("FAIL basic_char%0d: wr=%b ch=%h busy=%b done=%b, want 1 %h 1 0", i, wr_uart, uart_out, busy, done_tick, seq[i]);
      end
      tick();
    end
    #1;
    checks++;
    if (done_tick !== 1'b1 || busy !== 1'b0 || wr_uart !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: done=%b busy=%b wr=%b, want 1 0 0", done_tick, busy, wr_uart);
    end
    acc_in = 16'h9999; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    checks++;
    if (done_tick !== 1'b0 || busy !== 1'b0 || wr_uart !== 1'b0) begin
      failures++;
      $display("FAIL start_in_done: done=%b busy=%b wr=%b, want 0 0 0", done_tick, busy, wr_uart);
    end
    tick();
    #1;
    checks++;
    if (busy !== 1'b0 || wr_uart !== 1'b0) begin
      failures++;
      $display("FAIL start_in_done_idle: busy=%b wr=%b, want 0 0", busy, wr_uart);
    end
  endtask

  task automatic test_stall();
    set_seq(8'h31, 8'h41, 8'h32, 8'h46);
    tick();
    acc_in = 16'h1A2F; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    checks++;
    if (wr_uart !== 1'b1 || uart_out !== 8'h31) begin
      failures++;
      $display("FAIL stall_first: wr=%b ch=%h, want 1 31", wr_uart, uart_out);
    end
    tick();
    tx_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (wr_uart !== 1'b0 || uart_out !== 8'h41 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold%0d: wr=%b ch=%h busy=%b, want 0 41 1", i, wr_uart, uart_out, busy);
      end
      tick();
    end
    tx_full = 1'b0;
    for (int i = 1; i < 4 + TAIL; i++) begin
      #1;
      checks++;
      if (wr_uart !== 1'b1 || uart_out !== seq[i] || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_char%0d: wr=%b ch=%h busy=%b, want 1 %h 1", i, wr_uart, uart_out, busy, seq[i]);
      end
      tick();
    end
    #1;
    checks++;
    if (done_tick !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_done: done=%b busy=%b, want 1 0", done_tick, busy);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int n;
    n = 0;
    set_seq(8'h30, 8'h30, 8'h46, 8'h46);
    tick();
    acc_in = 16'h00FF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 4 + TAIL + 6; c++) begin
      if (c == 2) begin
        acc_in = 16'h1234; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (wr_uart === 1'b1) begin
        checks++;
        if (n >= 4 + TAIL || uart_out !== seq[n]) begin
          failures++;
          $display("FAIL ignore_char%0d: ch=%h, want %h", n, uart_out, (n < 4 + TAIL) ? seq[n] : 8'hXX);
        end
        n++;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (n != 4 + TAIL) begin
      failures++;
      $display("FAIL ignore_count: writes=%0d, want %0d", n, 4 + TAIL);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    tick();
    acc_in = 16'hBEEF; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    checks++;
    if (wr_uart !== 1'b1 || uart_out !== 8'h42) begin
      failures++;
      $display("FAIL rst_mid_b: wr=%b ch=%h, want 1 42", wr_uart, uart_out);
    end
    tick();
    #1;
    checks++;
    if (wr_uart !== 1'b1 || uart_out !== 8'h45) begin
      failures++;
      $display("FAIL rst_mid_e: wr=%b ch=%h, want 1 45", wr_uart, uart_out);
    end
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (wr_uart !== 1'b0 || uart_out !== 8'h00 || busy !== 1'b0 || done_tick !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_abort: wr=%b ch=%h busy=%b done=%b, want 0 00 0 0", wr_uart, uart_out, busy, done_tick);
    end
    tick();
    reset_n = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (wr_uart === 1'b1 || busy === 1'b1) n++;
      tick();
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL rst_mid_silent: active cycles=%0d, want 0", n);
    end
    set_seq(8'h30, 8'h30, 8'h30, 8'h31);
    acc_in = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4 + TAIL; i++) begin
      #1;
      checks++;
      if (wr_uart !== 1'b1 || uart_out !== seq[i]) begin
        failures++;
        $display("FAIL rst_restart_char%0d: wr=%b ch=%h, want 1 %h", i, wr_uart, uart_out, seq[i]);
      end
      tick();
    end
    #1;
    checks++;
    if (done_tick !== 1'b1) begin
      failures++;
      $display("FAIL rst_restart_done: done=%b, want 1", done_tick);
    end
    tick();
  endtask

  // Zero value; with the terminator enabled this covers the CR/LF tail.
  task automatic test_zero_crlf();
    set_seq(8'h30, 8'h30, 8'h30, 8'h30);
    tick();
    acc_in = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4 + TAIL; i++) begin
      #1;
      checks++;
      if (wr_uart !== 1'b1 || uart_out !== seq[i]) begin
        failures++;
        $display("FAIL zero_char%0d: wr=%b ch=%h, want 1 %h", i, wr_uart, uart_out, seq[i]);
      end
      tick();
    end
    #1;
    checks++;
    if (done_tick !== 1'b1 || wr_uart !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: done=%b wr=%b, want 1 0", done_tick, wr_uart);
    end
    tick();
  endtask

  task automatic test_acc_change();
    set_seq(8'h46, 8'h46, 8'h46, 8'h46);
    tick();
    acc_in = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4 + TAIL; i++) begin
      if (i == 1) acc_in = 16'h0000;
      #1;
      checks++;
      if (wr_uart !== 1'b1 || uart_out !== seq[i] || busy !== 1'b1) begin
        failures++;
        $display("FAIL accchg_char%0d: wr=%b ch=%h busy=%b, want 1 %h 1", i, wr_uart, uart_out, busy, seq[i]);
      end
      tick();
    end
    #1;
    checks++;
    if (done_tick !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL accchg_done: done=%b busy=%b, want 1 0", done_tick, busy);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_zero_crlf();
    test_acc_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
